vfu_cmd_queue: RTL

- Sits directly upstream of the Vfu command port, between the CPU CFU bus and the Vfu.
- Buffers incoming commands so the CPU can keep issuing while the vector processor is busy.
- Returns exactly one in-order CPU response per command.
- The Vfu response (valid pulse plus data) has no backpressure, so this block captures and holds it until the CPU accepts it.

---
 rtl/vfu_cmd_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vfu_cmd_queue.sv
// ============================================================================
//  Module      : vfu_cmd_queue
//  Description : Command buffer between the CPU CFU bus and the Vfu command
//                port. Accepted commands are queued toward the Vfu, and one
//                CPU response is returned per command, in accept order.
//                Vfu response pulses are captured and held until the CPU
//                accepts them.
//                Optional macro VFU_CMDQ_ERR_EN adds a sticky error flag
//                (err_stray_rsp) for stray Vfu responses or rdata overflow.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vfu_cmd_queue #(
    parameter int INSN_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 2,
    parameter int RSP_BIT    = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef VFU_CMDQ_ERR_EN
    output logic                  err_stray_rsp,
`endif
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [INSN_WIDTH-1:0] cmd_payload_instruction,
    input  logic [DATA_WIDTH-1:0] cmd_payload_inputs_0,
    input  logic [DATA_WIDTH-1:0] cmd_payload_inputs_1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_payload_output,
    output logic                  vfu_cmd_valid,
    input  logic                  vfu_cmd_ready,
    output logic [INSN_WIDTH-1:0] vfu_insn,
    output logic [DATA_WIDTH-1:0] vfu_in0,
    output logic [DATA_WIDTH-1:0] vfu_in1,
    input  logic                  vfu_rsp_valid,
    input  logic [DATA_WIDTH-1:0] vfu_rsp_data
);

    localparam int                  DEPTH   = 1 << DEPTH_BITS;
    localparam int                  CW      = DEPTH_BITS + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    // Command FIFO storage and state
    logic [INSN_WIDTH-1:0] cq_insn [DEPTH];
    logic [DATA_WIDTH-1:0] cq_in0  [DEPTH];
    logic [DATA_WIDTH-1:0] cq_in1  [DEPTH];
    logic [DEPTH_BITS-1:0] cq_wp, cq_rp;
    logic [CW-1:0]         cq_cnt;

    // Order FIFO: one kind bit per accepted command (1 = non-posted)
    logic [DEPTH-1:0]      ord_kind;
    logic [DEPTH_BITS-1:0] ord_wp, ord_rp;
    logic [CW-1:0]         ord_cnt;

    // Issued-but-unanswered commands, and issued non-posted ones lacking data
    logic [CW-1:0]         issued;
    logic [CW-1:0]         np_wait;

    // Response data FIFO
    logic [DATA_WIDTH-1:0] rd_mem [DEPTH];
    logic [DEPTH_BITS-1:0] rd_wp, rd_rp;
    logic [CW-1:0]         rd_cnt;

    logic accept, issue, respond, head_kind, issue_np;
    logic stray, rsp_ok, rd_full, rd_pop, capture;

    assign accept    = cmd_valid && cmd_ready;
    assign issue     = vfu_cmd_valid && vfu_cmd_ready;
    assign respond   = rsp_valid && rsp_ready;
    assign head_kind = ord_kind[ord_rp];
    assign issue_np  = issue && cq_insn[cq_rp][RSP_BIT];
    // A response with no issued non-posted command waiting for it is stray
    assign stray     = vfu_rsp_valid && (np_wait == '0);
    assign rsp_ok    = vfu_rsp_valid && !stray;
    assign rd_full   = (rd_cnt == DEPTH_C);
    assign rd_pop    = respond && head_kind;
    // Writing while full is only safe when the head slot is freed this cycle
    assign capture   = rsp_ok && (!rd_full || rd_pop);

    // cmd_ready comes only from registered occupancy, never from cmd_valid
    assign cmd_ready     = (ord_cnt != DEPTH_C);
    assign vfu_cmd_valid = (cq_cnt != '0);
    assign vfu_insn      = vfu_cmd_valid ? cq_insn[cq_rp] : '0;
    assign vfu_in0       = vfu_cmd_valid ? cq_in0[cq_rp]  : '0;
    assign vfu_in1       = vfu_cmd_valid ? cq_in1[cq_rp]  : '0;

    // The head may respond once issued; non-posted heads also need their data
    assign rsp_valid          = (ord_cnt != '0) && (issued != '0) &&
                                (!head_kind || (rd_cnt != '0));
    assign rsp_payload_output = ((ord_cnt != '0) && head_kind && (rd_cnt != '0))
                                ? rd_mem[rd_rp] : '0;

    // Payload storage; contents are only observed behind the counts
    always_ff @(posedge clk) begin
        if (accept) begin
            cq_insn[cq_wp] <= cmd_payload_instruction;
            cq_in0[cq_wp]  <= cmd_payload_inputs_0;
            cq_in1[cq_wp]  <= cmd_payload_inputs_1;
        end
        if (capture) begin
            rd_mem[rd_wp] <= vfu_rsp_data;
        end
    end

    // Pointers, counts and order bits; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cq_wp    <= '0;
            cq_rp    <= '0;
            cq_cnt   <= '0;
            ord_kind <= '0;
            ord_wp   <= '0;
            ord_rp   <= '0;
            ord_cnt  <= '0;
            issued   <= '0;
            np_wait  <= '0;
            rd_wp    <= '0;
            rd_rp    <= '0;
            rd_cnt   <= '0;
        end else begin
            if (accept) begin
                cq_wp            <= cq_wp + PTR_ONE;
                ord_wp           <= ord_wp + PTR_ONE;
                ord_kind[ord_wp] <= cmd_payload_instruction[RSP_BIT];
            end
            if (issue) begin
                cq_rp <= cq_rp + PTR_ONE;
            end
            if (respond) begin
                ord_rp <= ord_rp + PTR_ONE;
            end
            if (capture) begin
                rd_wp <= rd_wp + PTR_ONE;
            end
            if (rd_pop) begin
                rd_rp <= rd_rp + PTR_ONE;
            end
            cq_cnt  <= cq_cnt  + CW'(accept)   - CW'(issue);
            ord_cnt <= ord_cnt + CW'(accept)   - CW'(respond);
            issued  <= issued  + CW'(issue)    - CW'(respond);
            np_wait <= np_wait + CW'(issue_np) - CW'(rsp_ok);
            rd_cnt  <= rd_cnt  + CW'(capture)  - CW'(rd_pop);
        end
    end

`ifdef VFU_CMDQ_ERR_EN
    logic overflow;
    assign overflow = rsp_ok && rd_full && !rd_pop;

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_stray_rsp <= 1'b0;
        end else if (stray || overflow) begin
            err_stray_rsp <= 1'b1;
        end
    end

    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(stray || overflow));
`endif

endmodule

`default_nettype wire
